// File: rtl/menu_controller.sv
// Pushbutton-driven menu editor for the thermostat display: debounces the three
// board keys, edits one field at a time and keeps a free-running minute clock.
module menu_controller #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter logic [31:0] TICK_CYCLES       = 32'd3_000_000_000,
    parameter int unsigned TEMP_MIN          = 40,
    parameter int unsigned TEMP_MAX          = 110,
    parameter int unsigned TEMP_DEFAULT      = 75,
    parameter int unsigned HUM_MIN           = 20,
    parameter int unsigned HUM_MAX           = 90,
    parameter int unsigned HUM_DEFAULT       = 50,
    parameter int unsigned SUNRISE_H_DEFAULT = 6,
    parameter int unsigned SUNRISE_M_DEFAULT = 0
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [2:0]  KEY,
    output logic [3:0]  MENU_STATE,
    output logic [11:0] SET_TEMP_F,
    output logic [7:0]  SET_HUM,
    output logic [4:0]  TIME_HOURS,
    output logic [5:0]  TIME_MINUTES,
    output logic [4:0]  SUNRISE_HOURS,
    output logic [5:0]  SUNRISE_MINUTES
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SET_TEMP  = 4'd1,
        ST_SET_HUM   = 4'd2,
        ST_TIME_H    = 4'd3,
        ST_TIME_M    = 4'd4,
        ST_SUNRISE_H = 4'd5,
        ST_SUNRISE_M = 4'd6
    } menu_state_t;

    localparam int unsigned     DB_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);

    localparam logic [11:0] TEMP_LO  = 12'(TEMP_MIN);
    localparam logic [11:0] TEMP_HI  = 12'(TEMP_MAX);
    localparam logic [11:0] TEMP_DEF = 12'(TEMP_DEFAULT);
    localparam logic [7:0]  HUM_LO   = 8'(HUM_MIN);
    localparam logic [7:0]  HUM_HI   = 8'(HUM_MAX);
    localparam logic [7:0]  HUM_DEF  = 8'(HUM_DEFAULT);
    localparam logic [4:0]  SR_H_DEF = 5'(SUNRISE_H_DEFAULT);
    localparam logic [5:0]  SR_M_DEF = 6'(SUNRISE_M_DEFAULT);
    localparam logic [5:0]  HOUR_TOP = 6'd23;
    localparam logic [5:0]  MIN_TOP  = 6'd59;

    // ------------------------------------------------------------------
    // Key conditioning: synchronizer, debounce counter, press pulse
    // ------------------------------------------------------------------
    logic [2:0] press;

    for (genvar k = 0; k < 3; k++) begin : g_key
        logic [1:0]      sync_q;
        logic [DB_W-1:0] cnt_q;
        logic            level_q;
        logic            press_q;

        // NOTE: RESET is synchronous, so it lives inside the clocked branch and is
        // only honoured on a CLOCK_50 edge; the flops reset to "released".
        always_ff @(posedge CLOCK_50) begin
            if (RESET) begin
                sync_q  <= 2'b11;
                cnt_q   <= '0;
                level_q <= 1'b1;
                press_q <= 1'b0;
            end else begin
                // NOTE: non-blocking, so sync_q[1] takes the previous sync_q[0]
                // and the two stages really are two flops.
                sync_q  <= {sync_q[0], KEY[k]};
                press_q <= 1'b0;
                if (sync_q[1] == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_LAST) begin
                    cnt_q   <= '0;
                    level_q <= sync_q[1];
                    // Only the 1->0 (press) edge of the debounced level pulses.
                    press_q <= ~sync_q[1];
                end else begin
                    cnt_q <= cnt_q + DB_W'(1);
                end
            end
        end

        assign press[k] = press_q;
    end

    // ------------------------------------------------------------------
    // Press arbitration: NEXT wins, UP together with DOWN cancels out
    // ------------------------------------------------------------------
    logic next_p;
    logic edit_up;
    logic edit_down;
    logic edit_any;

    assign next_p    = press[0];
    assign edit_up   = ~press[0] &  press[1] & ~press[2];
    assign edit_down = ~press[0] & ~press[1] &  press[2];
    assign edit_any  = edit_up | edit_down;

    // ------------------------------------------------------------------
    // Field arithmetic
    // ------------------------------------------------------------------
    function automatic logic [11:0] temp_step(input logic [11:0] v, input logic up);
        if (up) return (v >= TEMP_HI) ? v : v + 12'd1;
        return (v <= TEMP_LO) ? v : v - 12'd1;
    endfunction

    function automatic logic [7:0] hum_step(input logic [7:0] v, input logic up);
        if (up) return (v >= HUM_HI) ? v : v + 8'd1;
        return (v <= HUM_LO) ? v : v - 8'd1;
    endfunction

    // Modular +/-1 over 0..top, shared by hours (top 23) and minutes (top 59).
    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                             input logic up);
        if (up) return (v >= top) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    // ------------------------------------------------------------------
    // Menu FSM, editable fields and minute clock
    // ------------------------------------------------------------------
    menu_state_t state_q;
    logic [31:0] prescale_q;
    logic        tick;
    logic        time_edit;

    assign tick      = (prescale_q == TICK_CYCLES - 32'd1);
    assign time_edit = edit_any & ((state_q == ST_TIME_H) | (state_q == ST_TIME_M));
    assign MENU_STATE = state_q;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q         <= ST_IDLE;
            prescale_q      <= '0;
            SET_TEMP_F      <= TEMP_DEF;
            SET_HUM         <= HUM_DEF;
            TIME_HOURS      <= 5'd0;
            TIME_MINUTES    <= 6'd0;
            SUNRISE_HOURS   <= SR_H_DEF;
            SUNRISE_MINUTES <= SR_M_DEF;
        end else begin
            // A manual time edit restarts the minute so the user sees a full one.
            if (time_edit || tick) begin
                prescale_q <= '0;
            end else begin
                prescale_q <= prescale_q + 32'd1;
            end

            if (next_p) begin
                state_q <= (state_q == ST_SUNRISE_M) ? ST_IDLE
                                                     : menu_state_t'(state_q + 4'd1);
            end

            if (edit_any) begin
                case (state_q)
                    ST_SET_TEMP:  SET_TEMP_F      <= temp_step(SET_TEMP_F, edit_up);
                    ST_SET_HUM:   SET_HUM         <= hum_step(SET_HUM, edit_up);
                    ST_TIME_H:    TIME_HOURS      <= 5'(wrap_step({1'b0, TIME_HOURS}, HOUR_TOP, edit_up));
                    ST_TIME_M:    TIME_MINUTES    <= wrap_step(TIME_MINUTES, MIN_TOP, edit_up);
                    ST_SUNRISE_H: SUNRISE_HOURS   <= 5'(wrap_step({1'b0, SUNRISE_HOURS}, HOUR_TOP, edit_up));
                    ST_SUNRISE_M: SUNRISE_MINUTES <= wrap_step(SUNRISE_MINUTES, MIN_TOP, edit_up);
                    default: ;
                endcase
            end

            // A tick landing on a time edit is dropped; the edit already restarted the minute.
            if (tick && !time_edit) begin
                TIME_MINUTES <= wrap_step(TIME_MINUTES, MIN_TOP, 1'b1);
                if (TIME_MINUTES >= MIN_TOP) begin
                    TIME_HOURS <= 5'(wrap_step({1'b0, TIME_HOURS}, HOUR_TOP, 1'b1));
                end
            end
        end
    end

endmodule
